// File: rtl/snek_pkg.sv
// ==== snek_pkg: shared direction codes and step-sequencer state encoding ==== Rev 1.0
`default_nettype none

package snek_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;
   localparam logic [1:0] DIR_RESET = DIR_RIGHT;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LATCH = 3'd1,
      MOVE  = 3'd2,
      CHECK = 3'd3,
      GROW  = 3'd4,
      DONE  = 3'd5,
      OVER  = 3'd6
   } step_state_t;

endpackage

`default_nettype wire

// File: rtl/snek_dir_filter.sv
// ==== snek_dir_filter: pending-direction register that drops 180-degree reversals ==== Rev 1.0
`default_nettype none

module snek_dir_filter
   import snek_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] dir_in,
   input  logic       dir_valid,
   input  logic [1:0] move_dir,
   output logic [1:0] pending_dir
);

   logic [1:0] r_pending_dir;
   logic       w_reversal;

   // Opposite directions differ only in bit 1 of the encoding.
   assign w_reversal = (dir_in == (move_dir ^ 2'd2));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending_dir <= DIR_RESET;
      end else if (dir_valid && !w_reversal) begin
         r_pending_dir <= dir_in;
      end
   end

   assign pending_dir = r_pending_dir;

endmodule

`default_nettype wire

// File: rtl/game_step_sequencer.sv
// ==== game_step_sequencer: runs latch/move/check/grow once per game_tick over req/ack ====
// ==== Optional ack watchdog under GAME_STEP_WDT_EN. Rev 1.0 ====
`default_nettype none

module game_step_sequencer
   import snek_pkg::*;
#(
   parameter int ACK_TIMEOUT = 1024,
   parameter int STEP_CNT_W  = 16
) (
   input  logic                  clk_100MHz,
   input  logic                  reset,
   input  logic                  game_tick,
   input  logic                  run,
   input  logic [1:0]            dir_in,
   input  logic                  dir_valid,
   output logic                  move_req,
   output logic [1:0]            move_dir,
   input  logic                  move_ack,
   output logic                  col_req,
   input  logic                  col_ack,
   input  logic                  col_hit,
   input  logic                  col_food,
   output logic                  grow_req,
   input  logic                  grow_ack,
   output logic                  busy,
   output logic                  game_over,
   output logic                  overrun,
   output logic [STEP_CNT_W-1:0] step_count,
   output logic                  timeout_err
);

   if (ACK_TIMEOUT < 1) begin : g_bad_timeout
      $error("ACK_TIMEOUT must be at least 1");
   end

   step_state_t           r_state, w_state_next;
   logic [1:0]            r_move_dir, w_pending_dir;
   logic                  r_move_req, r_col_req, r_grow_req, r_overrun;
   logic [STEP_CNT_W-1:0] r_step_count;
   logic                  w_busy, w_wait, w_ack, w_timeout;

   snek_dir_filter u_dir_filter (
      .clk         (clk_100MHz),
      .reset       (reset),
      .dir_in      (dir_in),
      .dir_valid   (dir_valid),
      .move_dir    (r_move_dir),
      .pending_dir (w_pending_dir)
   );

   assign w_busy = (r_state != IDLE) && (r_state != OVER);
   assign w_wait = (r_state == MOVE) || (r_state == CHECK) || (r_state == GROW);

   // The req of the current wait state is high for the whole state, so
   // qualifying the ack by state also ignores acks arriving while req is low.
   always_comb begin
      w_ack = 1'b0;
      case (r_state)
         MOVE:    w_ack = move_ack;
         CHECK:   w_ack = col_ack;
         GROW:    w_ack = grow_ack;
         default: w_ack = 1'b0;
      endcase
   end

`ifdef GAME_STEP_WDT_EN
   localparam int WDT_W = $clog2(ACK_TIMEOUT + 1);

   logic [WDT_W-1:0] r_wdt_cnt;
   logic             r_timeout_err;

   assign w_timeout = w_wait && !w_ack && (r_wdt_cnt == WDT_W'(ACK_TIMEOUT));

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         r_wdt_cnt     <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_state_next != r_state) begin
            r_wdt_cnt <= '0;
         end else if (w_wait && !w_ack) begin
            r_wdt_cnt <= r_wdt_cnt + 1'b1;
         end
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign timeout_err = r_timeout_err;
`else
   assign w_timeout   = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (game_tick && run) w_state_next = LATCH;
         LATCH:   w_state_next = MOVE;
         MOVE:    if (move_ack) w_state_next = CHECK;
         CHECK: begin
            if (col_ack) begin
               if (col_hit)       w_state_next = OVER;
               else if (col_food) w_state_next = GROW;
               else               w_state_next = DONE;
            end
         end
         GROW:    if (grow_ack) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         OVER:    w_state_next = OVER;
         default: w_state_next = IDLE;
      endcase
      if (w_timeout) begin
         w_state_next = OVER;
      end
   end

   // Requests are decoded from the next state so each one rises on state
   // entry and is already low in the cycle after its ack.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         r_state      <= IDLE;
         r_move_dir   <= DIR_RESET;
         r_move_req   <= 1'b0;
         r_col_req    <= 1'b0;
         r_grow_req   <= 1'b0;
         r_overrun    <= 1'b0;
         r_step_count <= '0;
      end else begin
         r_state    <= w_state_next;
         r_move_req <= (w_state_next == MOVE);
         r_col_req  <= (w_state_next == CHECK);
         r_grow_req <= (w_state_next == GROW);
         r_overrun  <= game_tick && w_busy;
         if (r_state == LATCH) begin
            r_move_dir <= w_pending_dir;
         end
         if (r_state == DONE) begin
            r_step_count <= r_step_count + 1'b1;
         end
      end
   end

   assign move_req   = r_move_req;
   assign col_req    = r_col_req;
   assign grow_req   = r_grow_req;
   assign move_dir   = r_move_dir;
   assign busy       = w_busy;
   assign game_over  = (r_state == OVER);
   assign overrun    = r_overrun;
   assign step_count = r_step_count;

endmodule

`default_nettype wire
